alu_flag_unit: RTL and testbench
================================

// Module: alu_flag_unit
// PURPOSE
//  Consumer end of the ALU result path. Accepts each ALU result with its selected
//  overflow bit (add/sub overflow already chosen by opcode) over a valid/ready
//  handshake, and registers the N/Z/C/V flags. Keeps a sticky overflow flag and a
//  saturating overflow event counter. Raises an interrupt on overflow, held until
//  acknowledged. Sits between the ALU datapath and the CPU status/interrupt logic.
// PARAMETERS
//  WIDTH      8  ALU result width in bits (>=2)
//  CNT_WIDTH  8  overflow event counter width (>=1)
// PORTS
//  Clk        in   1          clock, all state on rising edge
//  Rst_n      in   1          asynchronous active-low reset
//  Sel        in   3          ALU opcode: 3'b000 add, 3'b001 sub, others non-arith
//  Result     in   WIDTH      ALU result
//  CarryIn    in   1          adder carry-out / subtractor borrow
//  OvfIn      in   1          selected overflow bit; may be X when Sel is non-arith
//  InValid    in   1          Sel/Result/CarryIn/OvfIn valid this cycle
//  InReady    out  1          unit can accept a result this cycle
//  Flags      out  4          registered {N,Z,C,V}
//  StickyV    out  1          set on any accepted overflow; cleared by ClrSticky
//  OvfCount   out  CNT_WIDTH  number of accepted overflows, saturating
//  Irq        out  1          overflow interrupt request, level
//  IrqAck     in   1          interrupt acknowledge, single-cycle pulse
//  ClrSticky  in   1          clears StickyV and OvfCount
// BEHAVIOUR
//  - Clock Clk; reset Rst_n is asynchronous and active-low.
//  - Reset: Flags=0, StickyV=0, OvfCount=0, Irq=0, state=IDLE, InReady=1.
//  - Transfer occurs when InValid && InReady at a rising edge.
//  - Flag computation on the transfer cycle; values are visible on Flags the next cycle:
//    N=Result[WIDTH-1]; Z=(Result==0); C=CarryIn if Sel is 000/001, else 0;
//    V=OvfIn if Sel is 000/001, else 0. OvfIn must be gated by decode so that X
//    never reaches state for non-arith Sel.
//  - Flags hold their value between transfers.
//  - FSM has two states:
//    IDLE: InReady=1, Irq=0. A transfer with V=1 sets StickyV, increments
//      OvfCount (saturates at all-ones, no wrap), and moves to IRQ_PEND.
//      A transfer with V=0 updates Flags only and stays in IDLE.
//    IRQ_PEND: InReady=0 (backpressure), Irq=1. IrqAck moves to IDLE, so
//      Irq=0 and InReady=1 the next cycle.
//  - Irq latency: Irq is high the cycle after an overflow transfer.
//  - Minimum turnaround: one cycle from IrqAck to the next accept.
//  - IrqAck in IDLE is ignored.
//  - ClrSticky in any state clears StickyV and OvfCount next cycle. It does not
//    touch Flags, Irq or state.
//  - ClrSticky coinciding with an overflow transfer: set wins (StickyV=1, OvfCount=1).
//  - InValid with InReady=0: no effect. The upstream holds the data until it is accepted.
//  - Reset mid-IRQ_PEND: immediate return to reset values. The pending interrupt is lost.
// TESTING
//  1 Reset then add, Result=8'h00, CarryIn=1, OvfIn=0 -> next cycle Flags=4'b0110,
//    Irq=0, InReady=1.
//  2 Sub, Result=8'h80, OvfIn=1 -> Flags=4'b1001, StickyV=1, OvfCount=1, Irq=1,
//    InReady=0; a held InValid is not accepted until 1 cycle after IrqAck.
//  3 Sel=3'b010, OvfIn=X, Result=8'h05 -> Flags=4'b0000 with no X anywhere;
//    StickyV and OvfCount unchanged.
//  4 CNT_WIDTH=2, five overflow transfers (each acked) -> OvfCount=2'b11, no wrap;
//    ClrSticky -> 0.
//  5 ClrSticky asserted on the same edge as an overflow transfer -> StickyV=1, OvfCount=1.
//  6 Rst_n dropped asynchronously mid-IRQ_PEND -> Irq=0, InReady=1, all outputs zero
//    without waiting for a clock edge.

Source files
------------

// File: rtl/alu_flag_unit.sv
// alu_flag_unit: consumer end of the ALU result path.
// Registers N/Z/C/V for each accepted result, tracks a sticky overflow flag and
// a saturating overflow event counter, and raises a level interrupt on overflow
// that holds off further results until it is acknowledged.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | ready for a result, no interrupt pending
// IRQ_PEND | overflow seen, irq high, input backpressured until irq_ack
module alu_flag_unit #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           sel,
    input  logic [WIDTH-1:0]     result,
    input  logic                 carry_in,
    input  logic                 ovf_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [3:0]           flags,
    output logic                 sticky_v,
    output logic [CNT_WIDTH-1:0] ovf_count,
    output logic                 irq,
    input  logic                 irq_ack,
    input  logic                 clr_sticky
);

    typedef enum logic {
        IDLE     = 1'b0,
        IRQ_PEND = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic       xfer;
    logic       is_arith;
    logic       c_new;
    logic       v_new;
    logic       ovf_event;
    logic [3:0] flags_new;

    // decode gates carry/overflow so an undefined ovf_in on a non-arith op
    // can never reach the flag or counter registers
    always_comb begin
        is_arith  = (sel == 3'b000) || (sel == 3'b001);
        c_new     = is_arith ? carry_in : 1'b0;
        v_new     = is_arith ? ovf_in : 1'b0;
        xfer      = in_valid && in_ready;
        ovf_event = xfer && v_new;
        flags_new = {result[WIDTH-1], (result == '0), c_new, v_new};
    end

    // flag register, updated only on an accepted result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= 4'b0000;
        end else if (xfer) begin
            flags <= flags_new;
        end
    end

    // sticky overflow and saturating counter; an overflow on the same edge
    // as a clear wins and restarts the count at one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_v  <= 1'b0;
            ovf_count <= '0;
        end else if (ovf_event) begin
            sticky_v <= 1'b1;
            if (clr_sticky) begin
                ovf_count <= CNT_WIDTH'(1);
            end else if (ovf_count != '1) begin
                ovf_count <= ovf_count + CNT_WIDTH'(1);
            end
        end else if (clr_sticky) begin
            sticky_v  <= 1'b0;
            ovf_count <= '0;
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and handshake/interrupt outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        irq       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (ovf_event) begin
                    state_nxt = IRQ_PEND;
                end
            end
            IRQ_PEND: begin
                irq = 1'b1;
                if (irq_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_flag_unit.sv
// Bench for alu_flag_unit: directed vector table, random traffic against a
// behavioural model, counter saturation on a narrow-counter instance, and an
// asynchronous reset while an interrupt is pending.
module tb_alu_flag_unit;

    logic       clk;
    logic       rst_n;
    logic [2:0] sel;
    logic [7:0] result;
    logic       carry_in;
    logic       ovf_in;
    logic       in_valid;
    logic       irq_ack;
    logic       clr_sticky;

    logic       in_ready,  in_ready2;
    logic [3:0] flags,     flags2;
    logic       sticky_v,  sticky_v2;
    logic [7:0] ovf_count;
    logic [1:0] ovf_count2;
    logic       irq,       irq2;

    alu_flag_unit #(.WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .result(result),
        .carry_in(carry_in), .ovf_in(ovf_in), .in_valid(in_valid),
        .in_ready(in_ready), .flags(flags), .sticky_v(sticky_v),
        .ovf_count(ovf_count), .irq(irq), .irq_ack(irq_ack),
        .clr_sticky(clr_sticky)
    );

    alu_flag_unit #(.WIDTH(8), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .sel(sel), .result(result),
        .carry_in(carry_in), .ovf_in(ovf_in), .in_valid(in_valid),
        .in_ready(in_ready2), .flags(flags2), .sticky_v(sticky_v2),
        .ovf_count(ovf_count2), .irq(irq2), .irq_ack(irq_ack),
        .clr_sticky(clr_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // behavioural model
    bit       m_pend;
    bit [3:0] m_flags;
    bit       m_sticky;
    int       m_cnt8;
    int       m_cnt2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_pend = 0; m_flags = 0; m_sticky = 0; m_cnt8 = 0; m_cnt2 = 0;
    endtask

    task automatic model_step();
        bit arith, acc, v, ev;
        arith = (sel == 3'd0) || (sel == 3'd1);
        acc   = in_valid && !m_pend;
        v     = arith && (ovf_in === 1'b1);
        ev    = acc && v;
        if (acc) m_flags = {result[7], result == 8'd0, arith && carry_in, v};
        if (ev) begin
            m_sticky = 1;
            m_cnt8 = clr_sticky ? 1 : ((m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1);
            m_cnt2 = clr_sticky ? 1 : ((m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1);
        end else if (clr_sticky) begin
            m_sticky = 0; m_cnt8 = 0; m_cnt2 = 0;
        end
        if (m_pend && irq_ack) m_pend = 0;
        else if (ev) m_pend = 1;
    endtask

    // one clock: edge, settle, advance the model with the inputs seen at the edge
    task automatic step();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " flags"},   flags,      m_flags);
        chk({tag, " flags2"},  flags2,     m_flags);
        chk({tag, " irq"},     irq,        m_pend);
        chk({tag, " irq2"},    irq2,       m_pend);
        chk({tag, " ready"},   in_ready,   !m_pend);
        chk({tag, " ready2"},  in_ready2,  !m_pend);
        chk({tag, " sticky"},  sticky_v,   m_sticky);
        chk({tag, " sticky2"}, sticky_v2,  m_sticky);
        chk({tag, " cnt8"},    ovf_count,  m_cnt8[7:0]);
        chk({tag, " cnt2"},    ovf_count2, m_cnt2[1:0]);
    endtask

    task automatic idle_inputs();
        sel = 3'd0; result = 8'd0; carry_in = 0; ovf_in = 0;
        in_valid = 0; irq_ack = 0; clr_sticky = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        model_reset();
    endtask

    typedef struct {
        logic [2:0] sel;
        logic [7:0] res;
        logic       c;
        logic       ovf;
        logic       valid;
        logic       ack;
        logic       clr;
        logic [3:0] ef;
        logic       eirq;
        logic       erdy;
        logic       est;
        logic [7:0] ecnt;
    } vec_t;

    vec_t tbl[14];

    initial begin
        //          sel     res    c     ovf   vld ack clr  flags    irq rdy st cnt
        tbl[0]  = '{3'b000, 8'h00, 1'b1, 1'b0, 1, 0, 0, 4'b0110, 0, 1, 0, 8'd0};
        tbl[1]  = '{3'b001, 8'h80, 1'b0, 1'b1, 1, 0, 0, 4'b1001, 1, 0, 1, 8'd1};
        tbl[2]  = '{3'b001, 8'h7F, 1'b1, 1'b0, 1, 0, 0, 4'b1001, 1, 0, 1, 8'd1};
        tbl[3]  = '{3'b001, 8'h7F, 1'b1, 1'b0, 1, 1, 0, 4'b1001, 0, 1, 1, 8'd1};
        tbl[4]  = '{3'b001, 8'h7F, 1'b1, 1'b0, 1, 0, 0, 4'b0010, 0, 1, 1, 8'd1};
        tbl[5]  = '{3'b010, 8'h05, 1'b1, 1'bx, 1, 0, 0, 4'b0000, 0, 1, 1, 8'd1};
        tbl[6]  = '{3'b000, 8'h00, 1'b0, 1'b0, 0, 1, 0, 4'b0000, 0, 1, 1, 8'd1};
        tbl[7]  = '{3'b000, 8'h00, 1'b0, 1'b0, 0, 0, 1, 4'b0000, 0, 1, 0, 8'd0};
        tbl[8]  = '{3'b000, 8'hFF, 1'b1, 1'b1, 1, 0, 1, 4'b1011, 1, 0, 1, 8'd1};
        tbl[9]  = '{3'b000, 8'h00, 1'b0, 1'b0, 0, 1, 0, 4'b1011, 0, 1, 1, 8'd1};
        tbl[10] = '{3'b111, 8'h00, 1'b1, 1'b1, 1, 0, 0, 4'b0100, 0, 1, 1, 8'd1};
        tbl[11] = '{3'b001, 8'h40, 1'b0, 1'b1, 1, 0, 0, 4'b0001, 1, 0, 1, 8'd2};
        tbl[12] = '{3'b000, 8'h00, 1'b0, 1'b0, 0, 0, 1, 4'b0001, 1, 0, 0, 8'd0};
        tbl[13] = '{3'b000, 8'h00, 1'b0, 1'b0, 0, 1, 0, 4'b0001, 0, 1, 0, 8'd0};

        do_reset();
        chk("reset flags",  flags,     4'b0000);
        chk("reset irq",    irq,       1'b0);
        chk("reset ready",  in_ready,  1'b1);
        chk("reset sticky", sticky_v,  1'b0);
        chk("reset cnt",    ovf_count, 8'd0);

        // directed table
        for (int i = 0; i < 14; i++) begin
            sel = tbl[i].sel; result = tbl[i].res; carry_in = tbl[i].c;
            ovf_in = tbl[i].ovf; in_valid = tbl[i].valid;
            irq_ack = tbl[i].ack; clr_sticky = tbl[i].clr;
            step();
            chk($sformatf("row%0d flags", i),  flags,     tbl[i].ef);
            chk($sformatf("row%0d irq", i),    irq,       tbl[i].eirq);
            chk($sformatf("row%0d ready", i),  in_ready,  tbl[i].erdy);
            chk($sformatf("row%0d sticky", i), sticky_v,  tbl[i].est);
            chk($sformatf("row%0d cnt", i),    ovf_count, tbl[i].ecnt);
        end

        // counter saturation: five acked overflows, narrow counter stops at 3
        do_reset();
        for (int k = 0; k < 5; k++) begin
            idle_inputs();
            sel = 3'b000; result = 8'h81; ovf_in = 1; in_valid = 1;
            step();
            chk($sformatf("sat%0d irq", k), irq2, 1'b1);
            idle_inputs();
            irq_ack = 1;
            step();
        end
        chk("sat cnt2",    ovf_count2, 2'b11);
        chk("sat cnt8",    ovf_count,  8'd5);
        chk("sat sticky2", sticky_v2,  1'b1);
        idle_inputs();
        clr_sticky = 1;
        step();
        chk("sat clr cnt2",   ovf_count2, 2'b00);
        chk("sat clr sticky", sticky_v2,  1'b0);

        // random traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            sel        = 3'($urandom_range(0, 7));
            result     = 8'($urandom);
            if ($urandom_range(0, 7) == 0) result = 8'h00;
            carry_in   = 1'($urandom);
            ovf_in     = (sel <= 3'd1) ? 1'($urandom) : 1'bx;
            in_valid   = ($urandom_range(0, 9) < 7);
            irq_ack    = ($urandom_range(0, 9) < 3);
            clr_sticky = ($urandom_range(0, 19) == 0);
            step();
            chk_model($sformatf("rnd%0d", n));
        end

        // asynchronous reset while an interrupt is pending
        idle_inputs();
        irq_ack = 1;
        step();
        idle_inputs();
        sel = 3'b001; result = 8'h80; ovf_in = 1; in_valid = 1;
        step();
        chk("arst pre irq", irq, 1'b1);
        idle_inputs();
        #3 rst_n = 0;
        #1;
        chk("arst irq",    irq,       1'b0);
        chk("arst ready",  in_ready,  1'b1);
        chk("arst flags",  flags,     4'b0000);
        chk("arst sticky", sticky_v,  1'b0);
        chk("arst cnt",    ovf_count, 8'd0);
        chk("arst cnt2",   ovf_count2, 2'b00);
        @(posedge clk);
        #3 rst_n = 1;
        model_reset();
        step();
        chk_model("post arst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
